tlc_conflict_monitor: RTL and testbench

//  Independent safety monitor on the lamp-code bus driven by the traffic light controller (TL1..TL6).

---
 rtl/tlc_conflict_monitor.sv | 240 ++++++++++++++++++++++++
 tb/tb_tlc_conflict_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tlc_conflict_monitor.sv
// -----------------------------------------------------------------------------
// tlc_conflict_monitor
//
// Independent safety monitor placed between the traffic light controller and
// the lamp drivers. It samples the six 2-bit lamp codes every cycle and looks
// for conflicting non-red approaches, invalid codes, illegal colour sequences,
// short yellow phases and a stalled controller. The first violation latches a
// fault, freezes its cause, and forces all lamps to flashing red until an
// operator clear is accepted on a clean sample.
//
// Ports
//   clk          clock
//   reset        synchronous, active-low reset
//   tl1..tl6     lamp codes from controller: 0 green, 1 yellow, 2 red, 3 invalid
//   clear_fault  operator clear request (level, sampled every cycle)
//   out_tl       lamp codes to drivers, {tl6,...,tl1}, tl1 in [1:0]
//   lamp_en      lamp power enable (gates the flash in fault)
//   fault        latched fault flag
//   fault_code   0 none, 1 CONFLICT, 2 INVALID, 3 SEQ, 4 YEL_SHORT, 5 STUCK
//   fault_light  1..6 light index of captured fault, 0 if none or STUCK
// -----------------------------------------------------------------------------
module tlc_conflict_monitor #(
  parameter logic [14:0] PERMIT          = 15'h0CD0,
  parameter int          CONFLICT_TOL    = 2,
  parameter int          INVALID_TOL     = 2,
  parameter int          MIN_YELLOW      = 4,
  parameter int          WATCHDOG_CYCLES = 1024,
  parameter int          FLASH_HALF      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  tl1,
  input  logic [1:0]  tl2,
  input  logic [1:0]  tl3,
  input  logic [1:0]  tl4,
  input  logic [1:0]  tl5,
  input  logic [1:0]  tl6,
  input  logic        clear_fault,
  output logic [11:0] out_tl,
  output logic        lamp_en,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [2:0]  fault_light
);

  localparam logic [1:0]  GREEN   = 2'd0;
  localparam logic [1:0]  YELLOW  = 2'd1;
  localparam logic [1:0]  RED     = 2'd2;
  localparam logic [1:0]  BADCODE = 2'd3;
  localparam logic [11:0] ALL_RED = 12'hAAA;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_INVALID  = 3'd2;
  localparam logic [2:0] CODE_SEQ      = 3'd3;
  localparam logic [2:0] CODE_YEL      = 3'd4;
  localparam logic [2:0] CODE_STUCK    = 3'd5;

  localparam int CW = $clog2(CONFLICT_TOL + 1);
  localparam int IW = $clog2(INVALID_TOL + 1);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  typedef enum logic {MONITOR, FAULT} state_t;

  state_t        state;
  logic [1:0]    cur     [6];
  logic [1:0]    prev    [6];
  logic [7:0]    yel_cnt [6];
  logic [11:0]   cur_bus;
  logic [CW-1:0] conflict_cnt;
  logic [IW-1:0] invalid_cnt;
  logic [WW-1:0] wd_cnt;
  logic [FW-1:0] flash_cnt;

  assign cur[0]  = tl1;
  assign cur[1]  = tl2;
  assign cur[2]  = tl3;
  assign cur[3]  = tl4;
  assign cur[4]  = tl5;
  assign cur[5]  = tl6;
  assign cur_bus = {tl6, tl5, tl4, tl3, tl2, tl1};

  // Per-sample violation detection and lowest-index light capture.
  logic       conflict_now, invalid_now, seq_now, yel_now, change;
  logic [2:0] conflict_light, invalid_light, seq_light, yel_light;
  logic       conflict_hit, invalid_hit, stuck_hit, any_viol, trip;
  logic [2:0] next_code, next_light;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    int p;
    conflict_now   = 1'b0;
    conflict_light = 3'd0;
    invalid_now    = 1'b0;
    invalid_light  = 3'd0;
    seq_now        = 1'b0;
    seq_light      = 3'd0;
    yel_now        = 1'b0;
    yel_light      = 3'd0;
    change         = 1'b0;
    p              = 0;

    // Pair order 12,13,..,16,23,..,56: the first hit is the lowest-numbered pair.
    for (int i = 0; i < 5; i++) begin
      for (int j = i + 1; j < 6; j++) begin
        if (!PERMIT[p] && !conflict_now &&
            (cur[i] == GREEN || cur[i] == YELLOW) &&
            (cur[j] == GREEN || cur[j] == YELLOW)) begin
          conflict_now   = 1'b1;
          conflict_light = 3'(i + 1);
        end
        p = p + 1;
      end
    end

    for (int i = 5; i >= 0; i--) begin
      // Descending scan so the last assignment is the lowest index.
      if (cur[i] == BADCODE) begin
        invalid_now   = 1'b1;
        invalid_light = 3'(i + 1);
      end
      // Codes of 3 on either side fail all three patterns, so they are skipped.
      if ((prev[i] == GREEN  && cur[i] == RED)   ||
          (prev[i] == YELLOW && cur[i] == GREEN) ||
          (prev[i] == RED    && cur[i] == YELLOW)) begin
        seq_now   = 1'b1;
        seq_light = 3'(i + 1);
      end
      if (prev[i] == YELLOW && cur[i] == RED && yel_cnt[i] < 8'(MIN_YELLOW)) begin
        yel_now   = 1'b1;
        yel_light = 3'(i + 1);
      end
      if (cur[i] != prev[i]) change = 1'b1;
    end

    conflict_hit = conflict_now && (conflict_cnt == CW'(CONFLICT_TOL - 1));
    invalid_hit  = invalid_now  && (invalid_cnt  == IW'(INVALID_TOL - 1));
    stuck_hit    = !change      && (wd_cnt       == WW'(WATCHDOG_CYCLES - 1));
    any_viol     = conflict_now || invalid_now || seq_now || yel_now;
    trip         = conflict_hit || invalid_hit || seq_now || yel_now || stuck_hit;

    next_code  = CODE_NONE;
    next_light = 3'd0;
    if (conflict_hit) begin
      next_code  = CODE_CONFLICT;
      next_light = conflict_light;
    end else if (invalid_hit) begin
      next_code  = CODE_INVALID;
      next_light = invalid_light;
    end else if (seq_now) begin
      next_code  = CODE_SEQ;
      next_light = seq_light;
    end else if (yel_now) begin
      next_code  = CODE_YEL;
      next_light = yel_light;
    end else if (stuck_hit) begin
      next_code  = CODE_STUCK;
      next_light = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= MONITOR;
      out_tl       <= ALL_RED;
      lamp_en      <= 1'b1;
      fault        <= 1'b0;
      fault_code   <= CODE_NONE;
      fault_light  <= 3'd0;
      conflict_cnt <= '0;
      invalid_cnt  <= '0;
      wd_cnt       <= '0;
      flash_cnt    <= '0;
      // NOTE: the history and yellow-count arrays are real state checked on the
      // first sample after reset, so they are reset like any other register.
      for (int i = 0; i < 6; i++) begin
        prev[i]    <= RED;
        yel_cnt[i] <= 8'd0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in this
      // block overrides an earlier one for the same register.
      for (int i = 0; i < 6; i++) begin
        prev[i] <= cur[i];
        if (cur[i] == YELLOW)
          yel_cnt[i] <= (yel_cnt[i] == 8'hFF) ? yel_cnt[i] : yel_cnt[i] + 8'd1;
        else
          yel_cnt[i] <= 8'd0;
      end

      case (state)
        MONITOR: begin
          out_tl       <= cur_bus;
          lamp_en      <= 1'b1;
          conflict_cnt <= conflict_now ? conflict_cnt + CW'(1) : '0;
          invalid_cnt  <= invalid_now  ? invalid_cnt  + IW'(1) : '0;
          wd_cnt       <= change       ? '0 : wd_cnt + WW'(1);
          if (trip) begin
            state        <= FAULT;
            fault        <= 1'b1;
            fault_code   <= next_code;
            fault_light  <= next_light;
            out_tl       <= ALL_RED;
            lamp_en      <= 1'b0;
            flash_cnt    <= '0;
            conflict_cnt <= '0;
            invalid_cnt  <= '0;
            wd_cnt       <= '0;
          end
        end

        FAULT: begin
          out_tl <= ALL_RED;
          if (flash_cnt == FW'(FLASH_HALF - 1)) begin
            flash_cnt <= '0;
            lamp_en   <= ~lamp_en;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
          // A clear is honoured only on a sample that is itself clean.
          if (clear_fault && !any_viol) begin
            state       <= MONITOR;
            fault       <= 1'b0;
            fault_code  <= CODE_NONE;
            fault_light <= 3'd0;
            lamp_en     <= 1'b1;
            flash_cnt   <= '0;
            out_tl      <= cur_bus;
            for (int i = 0; i < 6; i++) yel_cnt[i] <= 8'd0;
          end
        end

        default: state <= MONITOR;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// -----------------------------------------------------------------------------
// tb_tlc_conflict_monitor
//
// Directed bench for tlc_conflict_monitor. The driver applies one input sample
// per cycle on the falling edge and queues the outputs expected after the next
// rising edge; an independent monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_tlc_conflict_monitor;

  localparam logic [1:0]  G = 2'd0;
  localparam logic [1:0]  Y = 2'd1;
  localparam logic [1:0]  R = 2'd2;
  localparam logic [1:0]  X = 2'd3;
  localparam logic [11:0] ALL_RED = 12'hAAA;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] tl_bus = ALL_RED;
  logic        clear_fault = 1'b0;
  logic [11:0] out_tl;
  logic        lamp_en;
  logic        fault;
  logic [2:0]  fault_code;
  logic [2:0]  fault_light;

  tlc_conflict_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .tl1         (tl_bus[1:0]),
    .tl2         (tl_bus[3:2]),
    .tl3         (tl_bus[5:4]),
    .tl4         (tl_bus[7:6]),
    .tl5         (tl_bus[9:8]),
    .tl6         (tl_bus[11:10]),
    .clear_fault (clear_fault),
    .out_tl      (out_tl),
    .lamp_en     (lamp_en),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_light (fault_light)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          when;
    string       name;
    bit          chk_out;
    logic [11:0] out;
    logic        en;
    logic        flt;
    logic [2:0]  code;
    logic [2:0]  light;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] mk(input logic [1:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  // Drive one sample, then queue what the DUT must show after the next edge.
  task automatic step(input string name, input logic [11:0] v, input logic clr,
                      input logic rst_n, input bit chk_out, input logic [11:0] o,
                      input logic en, input logic f, input logic [2:0] c,
                      input logic [2:0] l);
    exp_t e;
    @(negedge clk);
    tl_bus      = v;
    clear_fault = clr;
    reset       = rst_n;
    e.when    = cyc + 1;
    e.name    = name;
    e.chk_out = chk_out;
    e.out     = o;
    e.en      = en;
    e.flt     = f;
    e.code    = c;
    e.light   = l;
    q.push_back(e);
  endtask

  task automatic run_ok(input string name, input logic [11:0] v, input int n);
    for (int k = 0; k < n; k++) step(name, v, 1'b0, 1'b1, 1'b1, v, 1'b1, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic run_flt(input string name, input logic [11:0] v, input logic clr,
                         input logic en, input logic [2:0] c, input logic [2:0] l);
    step(name, v, clr, 1'b1, 1'b1, ALL_RED, en, 1'b1, c, l);
  endtask

  task automatic do_reset(input string name);
    step(name, ALL_RED, 1'b0, 1'b0, 1'b1, ALL_RED, 1'b1, 1'b0, 3'd0, 3'd0);
  endtask

  // Monitor: compare every queued expectation that is due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].when <= cyc) begin
        e = q.pop_front();
        if (e.chk_out) check({e.name, ".out_tl"}, out_tl, e.out);
        check({e.name, ".lamp_en"},     lamp_en,     e.en);
        check({e.name, ".fault"},       fault,       e.flt);
        check({e.name, ".fault_code"},  fault_code,  e.code);
        check({e.name, ".fault_light"}, fault_light, e.light);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [11:0] c12, v;

    // T1: legal cycle, pass-through with one cycle of latency.
    do_reset("t1_reset");
    run_ok("t1_g16", mk(G, R, R, R, R, G), 20);
    run_ok("t1_y16", mk(Y, R, R, R, R, Y), 4);
    run_ok("t1_red", ALL_RED, 2);
    run_ok("t1_g24", mk(R, G, R, G, R, R), 3);

    // T2: conflict tolerance, then fault and the flash pattern.
    do_reset("t2_reset");
    c12 = mk(G, G, R, R, R, R);
    run_ok("t2_conf1", c12, 1);
    run_ok("t2_inv1", mk(G, X, R, R, R, R), 1);
    run_ok("t2_clean", mk(G, R, R, R, R, R), 1);
    run_ok("t2_conf2a", c12, 1);
    run_flt("t2_entry", c12, 1'b0, 1'b0, 3'd1, 3'd1);
    for (int i = 1; i <= 16; i++)
      run_flt($sformatf("t2_flash%0d", i), c12, 1'b0, (i >= 8 && i < 16), 3'd1, 3'd1);
    do_reset("t2_reset_in_fault");

    // T3: direct green to red.
    run_ok("t3_g3", mk(R, R, G, R, R, R), 2);
    run_flt("t3_seq", ALL_RED, 1'b0, 1'b0, 3'd3, 3'd3);
    do_reset("t3_reset");

    // T4: short yellow faults, a full yellow does not.
    run_ok("t4_g2", mk(R, G, R, R, R, R), 1);
    run_ok("t4_y2", mk(R, Y, R, R, R, R), 2);
    run_flt("t4_yshort", ALL_RED, 1'b0, 1'b0, 3'd4, 3'd2);
    do_reset("t4_reset");
    run_ok("t4b_g2", mk(R, G, R, R, R, R), 1);
    run_ok("t4b_y4", mk(R, Y, R, R, R, R), 4);
    run_ok("t4b_red", ALL_RED, 2);

    // T5: priority, refused clear, accepted clear.
    v = mk(G, G, R, R, X, R);
    run_ok("t5_both1", v, 1);
    run_flt("t5_prio", v, 1'b0, 1'b0, 3'd1, 3'd1);
    run_flt("t5_clr_conf", v, 1'b1, 1'b0, 3'd1, 3'd1);
    run_flt("t5_clr_inv", mk(G, X, R, R, R, R), 1'b1, 1'b0, 3'd1, 3'd1);
    v = mk(G, R, R, R, R, R);
    step("t5_clear", v, 1'b1, 1'b1, 1'b1, v, 1'b1, 1'b0, 3'd0, 3'd0);
    run_ok("t5_after", v, 2);

    // T6: stalled controller, then reset out of the fault.
    do_reset("t6_reset");
    for (int k = 1; k <= 1024; k++) begin
      if (k == 1023)
        step("t6_wd1023", ALL_RED, 1'b0, 1'b1, 1'b1, ALL_RED, 1'b1, 1'b0, 3'd0, 3'd0);
      else if (k == 1024)
        run_flt("t6_stuck", ALL_RED, 1'b0, 1'b0, 3'd5, 3'd0);
      else begin
        @(negedge clk);
        tl_bus = ALL_RED; clear_fault = 1'b0; reset = 1'b1;
      end
    end
    run_flt("t6_hold", ALL_RED, 1'b0, 1'b0, 3'd5, 3'd0);
    do_reset("t6_reset_fault");
    run_ok("t6_resume", mk(R, R, R, G, R, R), 2);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
